// File: rtl/gpu_cmd_fifo.sv
// Command/parameter FIFO feeding a GPU word-serial command input.
// Every command goes out as a cmd, param, 0 frame; idle zeros only ever come in pairs.
module gpu_cmd_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [15:0]       wr_cmd,
    input  logic [15:0]       wr_param,
    output logic [15:0]       cpuline,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              zero_drop,
    output logic              busy
);

    typedef enum logic [2:0] {
        ST_IDLE_A = 3'd0,
        ST_IDLE_B = 3'd1,
        ST_CMD    = 3'd2,
        ST_PARAM  = 3'd3,
        ST_PAD    = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W + 1)'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [31:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_level;
    logic [ADDR_W:0]     w_level_nxt;
    logic                r_full;
    logic                r_empty;
    logic                r_overflow;
    logic                r_zero_drop;
    logic                r_busy;
    logic [15:0]         r_cpuline;
    logic [15:0]         w_cpuline_nxt;
    logic [31:0]         w_head;
    logic                w_accept;
    logic                w_pop;
    logic                w_drop_full;
    logic                w_drop_zero;

    // A full FIFO drops the write even when the head is popped on the same edge.
    assign w_head      = r_mem[r_rd_ptr];
    assign w_drop_full = wr_en & r_full;
    assign w_drop_zero = wr_en & (wr_cmd == 16'h0000);
    assign w_accept    = wr_en & ~r_full & (wr_cmd != 16'h0000);
    assign w_pop       = (r_state == ST_PARAM);

    // Occupancy after this edge's accept and pop.
    always_comb begin
        w_level_nxt = r_level;
        if (w_accept && !w_pop) begin
            w_level_nxt = r_level + LVL_ONE;
        end else if (!w_accept && w_pop) begin
            w_level_nxt = r_level - LVL_ONE;
        end else begin
            w_level_nxt = r_level;
        end
    end

    // Frame sequencer next state and the word it puts on the line.
    always_comb begin
        w_state_nxt   = r_state;
        w_cpuline_nxt = 16'h0000;
        case (r_state)
            ST_IDLE_A: w_state_nxt = ST_IDLE_B;
            ST_IDLE_B: begin
                if (!r_empty) begin
                    w_state_nxt = ST_CMD;
                end else begin
                    w_state_nxt = ST_IDLE_A;
                end
            end
            ST_CMD:    w_state_nxt = ST_PARAM;
            ST_PARAM:  w_state_nxt = ST_PAD;
            ST_PAD: begin
                if (!r_empty) begin
                    w_state_nxt = ST_CMD;
                end else begin
                    w_state_nxt = ST_IDLE_A;
                end
            end
            default:   w_state_nxt = ST_IDLE_A;
        endcase
        case (w_state_nxt)
            ST_CMD:   w_cpuline_nxt = w_head[31:16];
            ST_PARAM: w_cpuline_nxt = w_head[15:0];
            default:  w_cpuline_nxt = 16'h0000;
        endcase
    end

    // Entry storage; the slot under the read pointer is never written while it is the head.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= {wr_cmd, wr_param};
        end
    end

    // Sequencer, pointers, status and sticky drop flags.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= ST_IDLE_A;
            r_cpuline   <= 16'h0000;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_zero_drop <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cpuline <= w_cpuline_nxt;
            r_busy    <= (w_state_nxt == ST_CMD) || (w_state_nxt == ST_PARAM) ||
                         (w_state_nxt == ST_PAD);
            r_level   <= w_level_nxt;
            r_full    <= (w_level_nxt == LVL_FULL);
            r_empty   <= (w_level_nxt == '0);
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop_full) begin
                r_overflow <= 1'b1;
            end
            if (w_drop_zero) begin
                r_zero_drop <= 1'b1;
            end
        end
    end

    assign cpuline   = r_cpuline;
    assign full      = r_full;
    assign empty     = r_empty;
    assign level     = r_level;
    assign overflow  = r_overflow;
    assign zero_drop = r_zero_drop;
    assign busy      = r_busy;

endmodule

// File: doc/gpu_cmd_fifo.md
GPU_CMD_FIFO -- requirements
Module: gpu_cmd_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of queued command/param pairs (power of two).
REQ-002 SHALL have parameter ADDR_W, default 4, meaning log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1 bit: the CPU write strobe, sampled each rising edge.
REQ-006 SHALL have port wr_cmd, input, 16 bits: the GPU opcode (0xC0..0xC6 in current use).
REQ-007 SHALL have port wr_param, input, 16 bits: the operand for wr_cmd.
REQ-008 SHALL have port cpuline, output, 16 bits, registered: the word stream to the GPU command input.
REQ-009 SHALL have ports full and empty, outputs, 1 bit each: FIFO status.
REQ-010 SHALL have port level, output, ADDR_W+1 bits: the number of stored pairs.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag for a write dropped because the FIFO was full.
REQ-012 SHALL have port zero_drop, output, 1 bit: sticky flag for a write dropped because wr_cmd was 0.
REQ-013 SHALL have port busy, output, 1 bit: high in states CMD, PARAM and PAD.

Function
REQ-014 SHALL store {wr_cmd, wr_param} as one 32-bit entry per accepted write, first in, first out.
REQ-015 SHALL accept a write when wr_en=1, full=0 and wr_cmd!=0.
REQ-016 SHALL drop a write when wr_en=1 and full=1, even if a pop occurs in the same cycle, and SHALL set overflow.
REQ-017 SHALL drop a write when wr_en=1 and wr_cmd=0, and SHALL set zero_drop; an opcode of 0 would break GPU word phase.
REQ-018 SHALL update level by +1 on an accept, by -1 on a pop, and leave it unchanged when both occur in the same cycle.
REQ-019 SHALL drive full = (level==DEPTH) and empty = (level==0), with pointer wrap modulo DEPTH.
REQ-020 SHALL implement the FSM states IDLE_A, IDLE_B, CMD, PARAM and PAD.
REQ-021 SHALL register cpuline on the same edge as the state, with these values:
- IDLE_A, IDLE_B, PAD: 0x0000
- CMD: the head cmd
- PARAM: the head param
REQ-022 SHALL make these FSM transitions:
- IDLE_A goes to IDLE_B unconditionally.
- IDLE_B goes to CMD if !empty, else to IDLE_A.
- CMD goes to PARAM.
- PARAM goes to PAD, and the head is popped on that edge.
- PAD goes to CMD if !empty (post-pop), else to IDLE_A.
REQ-023 SHALL emit idle zeros only in complete pairs (IDLE_A, IDLE_B) and emit each command as the 3-word frame cmd, param, 0. This matches the GPU's 2-word capture plus 1 execute cycle, so the GPU NOP phase is always preserved.
REQ-024 SHALL present a write accepted into an empty FIFO at edge E as the cmd word on cpuline after edge E+1 (state at E was IDLE_A->IDLE_B) or after edge E+2 (state at E was IDLE_B->IDLE_A).
REQ-025 SHALL, for back-to-back queued commands, issue one frame every 3 cycles with no idle words between frames.
REQ-026 SHALL keep the head entry stable from CMD through PARAM; writes during a frame never alter the frame in flight.
REQ-027 SHALL allow level to reach DEPTH while a frame is in flight, and SHALL free the slot at the PARAM->PAD edge.

Reset
REQ-028 SHALL, while clr=0, asynchronously force state=IDLE_A, cpuline=0, both pointers=0, level=0, empty=1, full=0, overflow=0, zero_drop=0 and busy=0.
REQ-029 SHALL, on reset mid-frame, abandon the frame and discard all queued entries; clr is shared with the GPU so both restart at a word boundary.
REQ-030 SHALL resume with IDLE_A on the first rising edge after clr returns to 1.

Verification
REQ-031 SHALL cover a single write of 0xC1/0x0041 into an empty FIFO -> cpuline shows 0x00C1, 0x0041, 0x0000 on consecutive cycles, then idle pairs; level goes 1->0 at the PARAM->PAD edge.
REQ-032 SHALL cover 3 back-to-back writes (C4/5, C3/2, C1/0x48) -> 9 consecutive words C4,5,0,C3,2,0,C1,48,0 with no gaps; an attached GPU model ends with pointer=85 and ram[85]=0x48.
REQ-033 SHALL cover DEPTH+2 writes with no drain (FSM held off by writing during reset release) -> full=1 at level 16, overflow=1, and the first 16 entries emitted in order.
REQ-034 SHALL cover a write with wr_cmd=0 -> entry not stored, level unchanged, zero_drop=1, and the cpuline idle pattern unaffected.
REQ-035 SHALL cover simultaneous write and pop at level 5 -> level stays 5.
REQ-036 SHALL cover clr pulsed low during PARAM of a frame with 4 entries queued -> cpuline=0, level=0, flags=0 immediately; after release, only zeros until a new write.
